// File: rtl/alu_div_unit_pkg.sv
// Shared ALU select codes and divider state encoding, used by the ALU,
// the decoder and the iterative divide unit.
package alu_div_unit_pkg;

    localparam logic [5:0] SEL_ADD    = 6'b000000;
    localparam logic [5:0] SEL_SUB    = 6'b000001;
    localparam logic [5:0] SEL_SLL    = 6'b000010;
    localparam logic [5:0] SEL_SLT    = 6'b000011;
    localparam logic [5:0] SEL_SLTU   = 6'b000100;
    localparam logic [5:0] SEL_XOR    = 6'b000101;
    localparam logic [5:0] SEL_SRL    = 6'b000110;
    localparam logic [5:0] SEL_SRA    = 6'b000111;
    localparam logic [5:0] SEL_MUL    = 6'b001000;
    localparam logic [5:0] SEL_MULH   = 6'b001001;
    localparam logic [5:0] SEL_MULHSU = 6'b001010;
    localparam logic [5:0] SEL_MULHU  = 6'b001011;
    localparam logic [5:0] SEL_DIV    = 6'b001100;
    localparam logic [5:0] SEL_DIVU   = 6'b001101;
    localparam logic [5:0] SEL_REM    = 6'b001110;
    localparam logic [5:0] SEL_REMU   = 6'b001111;
    localparam logic [5:0] SEL_OR     = 6'b010000;
    localparam logic [5:0] SEL_AND    = 6'b010001;

    // Upper four SELECT bits shared by DIV/DIVU/REM/REMU; the low two pick the op.
    localparam logic [3:0] SEL_DIV_GRP = 4'b0011;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CALC    = 3'd1,
        ST_FIX     = 3'd2,
        ST_SPECIAL = 3'd3,
        ST_DONE    = 3'd4
    } div_state_t;

endpackage

// File: rtl/alu_div_unit_div_step.sv
// One restoring radix-2 division iteration on unsigned magnitudes.
module alu_div_unit_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quot,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quot_next
);

    logic [WIDTH:0] rem_sh;
    logic           fits;

    always_comb begin
        rem_sh = {rem, quot[WIDTH-1]};
        // The shifted partial remainder needs one extra bit; once it is known to
        // be >= divisor, the difference is < divisor and fits in WIDTH bits.
        fits   = (rem_sh >= {1'b0, divisor});
        if (fits) begin
            rem_next  = rem_sh[WIDTH-1:0] - divisor;
            quot_next = {quot[WIDTH-2:0], 1'b1};
        end else begin
            rem_next  = rem_sh[WIDTH-1:0];
            quot_next = {quot[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/alu_div_unit.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit for the EX stage; BUSY stalls the
// pipeline while a division runs, DONE pulses with RESULT valid.
module alu_div_unit
    import alu_div_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             START,
    input  logic [5:0]       SELECT,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    input  logic             FLUSH,
    output logic [WIDTH-1:0] RESULT,
    output logic             BUSY,
    output logic             DONE
);

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    div_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quot_r;
    logic [WIDTH-1:0] dvsr_r;
    logic [1:0]       op_r;
    logic             neg_q_r;
    logic             neg_r_r;
    logic             zero_r;

    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] quot_nx;
    logic             accept;
    logic             is_signed;
    logic             div_zero;
    logic             overflow;

    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                   input logic sgn);
        logic signed [WIDTH-1:0] neg_v;
        neg_v = -v;
        return (sgn && v[WIDTH-1]) ? WIDTH'(neg_v) : WIDTH'(v);
    endfunction

    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] mag,
                                                    input logic neg);
        logic signed [WIDTH-1:0] s_mag;
        s_mag = $signed(mag);
        return neg ? WIDTH'(-s_mag) : mag;
    endfunction

    assign accept    = START && !FLUSH && (SELECT[5:2] == SEL_DIV_GRP);
    assign is_signed = !SELECT[0];
    assign div_zero  = (DATA2 == '0);
    assign overflow  = is_signed && (DATA1 == MOST_NEG) && (DATA2 == ALL_ONES);

    alu_div_unit_div_step #(
        .WIDTH     (WIDTH)
    ) u_step (
        .rem       (rem_r),
        .quot      (quot_r),
        .divisor   (dvsr_r),
        .rem_next  (rem_nx),
        .quot_next (quot_nx)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            rem_r   <= '0;
            quot_r  <= '0;
            dvsr_r  <= '0;
            op_r    <= '0;
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
            zero_r  <= 1'b0;
            RESULT  <= '0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
        end else begin
            DONE <= 1'b0;
            if (FLUSH && (state != ST_IDLE)) begin
                state <= ST_IDLE;
                BUSY  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (accept) begin
                            op_r  <= SELECT[1:0];
                            BUSY  <= 1'b1;
                            rem_r <= '0;
                            cnt   <= CNT_W'(WIDTH);
                            if (div_zero || overflow) begin
                                // Raw dividend is the answer for REM/0 and DIV overflow.
                                quot_r <= DATA1;
                                zero_r <= div_zero;
                                state  <= ST_SPECIAL;
                            end else begin
                                quot_r  <= magnitude(DATA1, is_signed);
                                dvsr_r  <= magnitude(DATA2, is_signed);
                                neg_q_r <= is_signed && (DATA1[WIDTH-1] ^ DATA2[WIDTH-1]);
                                neg_r_r <= is_signed && DATA1[WIDTH-1];
                                zero_r  <= 1'b0;
                                state   <= ST_CALC;
                            end
                        end
                    end
                    ST_CALC: begin
                        rem_r  <= rem_nx;
                        quot_r <= quot_nx;
                        cnt    <= cnt - 1'b1;
                        if (cnt == CNT_W'(1)) begin
                            state <= ST_FIX;
                        end
                    end
                    ST_FIX: begin
                        RESULT <= op_r[1] ? apply_sign(rem_r, neg_r_r)
                                          : apply_sign(quot_r, neg_q_r);
                        DONE   <= 1'b1;
                        BUSY   <= 1'b0;
                        state  <= ST_DONE;
                    end
                    ST_SPECIAL: begin
                        if (zero_r) begin
                            RESULT <= op_r[1] ? quot_r : ALL_ONES;
                        end else begin
                            RESULT <= op_r[1] ? '0 : quot_r;
                        end
                        DONE  <= 1'b1;
                        BUSY  <= 1'b0;
                        state <= ST_DONE;
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                        BUSY  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alu_div_unit.sv
// Bench for alu_div_unit: directed vector table, abort/filter sequences and
// randomized operations against an integer-arithmetic reference model.
module tb_alu_div_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [5:0]  sel;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        flush;
    logic [31:0] result;
    logic        busy;
    logic        done;

    int total;
    int passed;

    alu_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .CLK     (clk),
        .RESET_N (rst_n),
        .START   (start),
        .SELECT  (sel),
        .DATA1   (d1),
        .DATA2   (d2),
        .FLUSH   (flush),
        .RESULT  (result),
        .BUSY    (busy),
        .DONE    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[16];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
        else passed++;
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        else passed++;
    endtask

    // Reference: 64-bit integer division; RISC-V truncation semantics fall out
    // naturally, including the most-negative / -1 case.
    function automatic logic [31:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb, ua, ub, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        if (b == 32'h0) return op[1] ? a : 32'hFFFF_FFFF;
        case (op)
            2'b00:   r = sa / sb;
            2'b01:   r = ua / ub;
            2'b10:   r = sa % sb;
            default: r = ua % ub;
        endcase
        return r[31:0];
    endfunction

    function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'h0) return 2;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
        return 34;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic start_op(input logic [5:0] s, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        sel   = s;
        d1    = a;
        d2    = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        sel   = 6'($urandom);
        d1    = $urandom;
        d2    = $urandom;
    endtask

    // Runs one operation; lat is the cycle (1 = first after accept) DONE is seen.
    task automatic do_op(input logic [5:0] s, input logic [31:0] a, input logic [31:0] b,
                         input bit noise, output logic [31:0] res, output int lat,
                         output int busy_cycles);
        res = 32'hDEAD_BEEF;
        lat = -1;
        busy_cycles = 0;
        start_op(s, a, b);
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (busy) busy_cycles++;
            if (done) begin
                res   = result;
                lat   = c;
                start = 1'b0;
                break;
            end
            if (noise) begin
                start = 1'($urandom_range(0, 1));
                sel   = {4'b0011, 2'($urandom)};
                d1    = $urandom;
                d2    = $urandom;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        logic [31:0] res;
        logic [31:0] exp;
        logic [31:0] held;
        int          lat;
        int          bc;
        int          seen;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        bit          noise;

        total  = 0;
        passed = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        flush  = 1'b0;
        sel    = 6'h0;
        d1     = 32'h0;
        d2     = 32'h0;

        vecs[0]  = '{6'b001100, 32'd3,          32'd2,          32'd1,          34};
        vecs[1]  = '{6'b001100, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  34};
        vecs[2]  = '{6'b001110, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  34};
        vecs[3]  = '{6'b001101, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  34};
        vecs[4]  = '{6'b001111, 32'd3,          32'd2,          32'd1,          34};
        vecs[5]  = '{6'b001101, 32'd5,          32'd0,          32'hFFFF_FFFF,  2};
        vecs[6]  = '{6'b001111, 32'd5,          32'd0,          32'd5,          2};
        vecs[7]  = '{6'b001100, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  2};
        vecs[8]  = '{6'b001110, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          2};
        vecs[9]  = '{6'b001100, 32'd7,          32'd0,          32'hFFFF_FFFF,  2};
        vecs[10] = '{6'b001110, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9,  2};
        vecs[11] = '{6'b001101, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          34};
        vecs[12] = '{6'b001100, 32'h8000_0000,  32'd1,          32'h8000_0000,  34};
        vecs[13] = '{6'b001100, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  34};
        vecs[14] = '{6'b001110, 32'd7,          32'hFFFF_FFFE,  32'd1,          34};
        vecs[15] = '{6'b001111, 32'hFFFF_FFFF,  32'h0001_0000,  32'h0000_FFFF,  34};

        repeat (3) @(negedge clk);
        check32("reset_result", result, 32'h0);
        check_int("reset_busy", int'(busy), 0);
        check_int("reset_done", int'(done), 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            do_op(vecs[i].sel, vecs[i].a, vecs[i].b, (i % 3) == 2, res, lat, bc);
            check32($sformatf("vec%0d_result", i), res, vecs[i].exp);
            check_int($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            check_int($sformatf("vec%0d_busy_cycles", i), bc, vecs[i].lat - 1);
        end

        // Non-divide select codes must not start anything.
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            start = 1'b1;
            sel   = (k == 0) ? 6'b000000 : 6'b001000;
            d1    = 32'd9;
            d2    = 32'd3;
            @(negedge clk);
            start = 1'b0;
            seen = 0;
            repeat (4) begin
                @(negedge clk);
                if (busy || done) seen++;
            end
            check_int($sformatf("filter%0d_no_activity", k), seen, 0);
        end

        // FLUSH together with START in IDLE: nothing accepted.
        @(negedge clk);
        start = 1'b1;
        flush = 1'b1;
        sel   = 6'b001100;
        d1    = 32'd9;
        d2    = 32'd3;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (busy || done) seen++;
        end
        check_int("flush_idle_no_accept", seen, 0);

        do_op(6'b001100, 32'd100, 32'd7, 1'b0, held, lat, bc);
        check32("pre_flush_result", held, 32'd14);

        // Flush a running DIV at cycle 10.
        start_op(6'b001100, 32'd1000, 32'd3);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check_int("flush_busy_low", int'(busy), 0);
        check32("flush_result_held", result, held);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen++;
        end
        check_int("flush_no_done", seen, 0);

        // Asynchronous reset in the middle of a division.
        start_op(6'b001100, 32'd1000, 32'd3);
        repeat (20) @(negedge clk);
        check_int("pre_reset_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check32("async_reset_result", result, 32'h0);
        check_int("async_reset_busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(6'b001100, 32'd3, 32'd2, 1'b0, res, lat, bc);
        check32("post_reset_result", res, 32'd1);
        check_int("post_reset_latency", lat, 34);

        // Randomized operations with operand scrambling and START noise.
        for (int n = 0; n < 150; n++) begin
            op    = 2'($urandom_range(0, 3));
            a     = pick_operand();
            b     = pick_operand();
            noise = 1'($urandom_range(0, 1));
            exp   = ref_model(op, a, b);
            do_op({4'b0011, op}, a, b, noise, res, lat, bc);
            check32($sformatf("rand%0d_op%0d_%h_%h", n, op, a, b), res, exp);
            check_int($sformatf("rand%0d_latency", n), lat, ref_lat(op, a, b));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/alu_div_unit.md
Name: alu_div_unit

Overview:
- Iterative radix-2 divide/remainder unit serving the RV32M DIV, DIVU, REM and REMU select codes (6'b001100-6'b001111) in the EX stage.
- Sits beside the combinational ALU and consumes the same DATA1/DATA2/SELECT operands.
- Produces a 32-bit RESULT for the EX/MEM result mux.
- Asserts BUSY so the hazard unit can stall the pipeline while a division is in flight.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- START  in  1  request; sampled only in IDLE.
- SELECT  in  6  ALU operation code; only 6'b0011xx is accepted.
- DATA1  in  WIDTH  dividend.
- DATA2  in  WIDTH  divisor.
- FLUSH  in  1  abort the in-flight operation (pipeline flush).
- RESULT  out  WIDTH  quotient or remainder; held until the next accepted START.
- BUSY  out  1  high from the cycle after accept until DONE.
- DONE  out  1  one-cycle pulse; RESULT is valid in the same cycle.

Behaviour:
- Reset (asynchronous, any state):
  - State returns to IDLE.
  - RESULT=0, BUSY=0, DONE=0.
  - Counter and internal registers cleared.
- Accept condition: in IDLE, START=1 and SELECT[5:2]==4'b0011 at the clock edge.
  - Latch DATA1, DATA2 and SELECT[1:0] (op: 00 DIV, 01 DIVU, 10 REM, 11 REMU).
  - START with any other SELECT is ignored: stay in IDLE, no BUSY.
- States:
  - IDLE: wait for accept. Accept goes to SPECIAL if the divisor is zero or on signed overflow; otherwise to CALC with counter=WIDTH.
  - CALC: signed ops work on magnitudes. Each cycle shifts {rem,quot} left 1, does a trial subtract of |divisor|, sets the quotient bit if the result is non-negative, and decrements the counter. Goes to FIX when the counter reaches 0 after the WIDTH-th iteration.
  - FIX: one cycle. Apply signs: quotient is negated if the operand signs differ; remainder takes the sign of the dividend. Load RESULT, go to DONE.
  - SPECIAL: one cycle. Load RESULT per the rules below, go to DONE.
  - DONE: DONE=1 for exactly one cycle, then IDLE.
- Special results:
  - Divide by zero: DIV/DIVU give 32'hFFFFFFFF; REM/REMU give the latched DATA1.
  - Signed overflow (DIV/REM, dividend 32'h80000000, divisor 32'hFFFFFFFF): DIV gives 32'h80000000; REM gives 0.
- Latency, counted from the accept edge to the DONE-high cycle:
  - Normal path: WIDTH+2 cycles (34 at default).
  - Special path: 2 cycles.
- BUSY: high in CALC, FIX and SPECIAL; low in IDLE and DONE. The next START can be accepted in the cycle after DONE.
- START while not IDLE: ignored. Operand or SELECT changes after accept have no effect.
- FLUSH: in any non-IDLE state, go to IDLE on the next edge. No DONE pulse, RESULT unchanged, BUSY low the next cycle. FLUSH in IDLE outranks START, so nothing is accepted.
- RESULT is updated only on entry to DONE.

Decomposition:
- Shared package holds:
  - the 6-bit ALU SELECT codes (DIV/DIVU/REM/REMU plus the others), for the ALU, decoder and this unit;
  - state encodings: IDLE, CALC, FIX, SPECIAL, DONE.
- One natural sub-module: div_step. Combinational single iteration taking rem, quot and divisor, producing next rem and next quot.

Test Plan:
- DIV 3/2 (SELECT 001100): RESULT=1, DONE 34 cycles after accept, BUSY high for cycles 1-33.
- DIV 32'hFFFFFFF9/2 gives 32'hFFFFFFFD; REM of the same gives 32'hFFFFFFFF; DIVU 32'hFFFFFFFF/1 gives 32'hFFFFFFFF; REMU 3/2 gives 1.
- Divide by zero: DIVU 5/0 gives 32'hFFFFFFFF and REMU 5/0 gives 5, both with DONE 2 cycles after accept.
- Overflow: DIV 32'h80000000/32'hFFFFFFFF gives 32'h80000000; REM of the same gives 0; DONE at 2 cycles.
- Abort: FLUSH at cycle 10 of a DIV leaves no DONE and RESULT unchanged. RESET_N low at cycle 20 gives RESULT=0 and BUSY=0 immediately. A following DIV 3/2 completes normally.
- Filtering: START with SELECT 000000 gives no BUSY. START pulses during BUSY are ignored, and operand changes mid-op do not alter the result.
